// File: rtl/dm_sba_arbiter_pkg.sv
// Shared types for the debug-module system-bus arbiter: FSM states, the
// captured request record, the adapter request type and the port-index width
// helper. The RSP state exists only when DM_SBA_ARB_RSP_REG_EN is defined.
package dm_sba_arbiter_pkg;

    // Adapter request kind; this arbiter only ever issues single-word requests.
    typedef enum logic [1:0] {
        SINGLE_REQ     = 2'd0,
        CACHE_LINE_REQ = 2'd1
    } ad_req_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
`ifdef DM_SBA_ARB_RSP_REG_EN
        ,RSP     = 2'd3
`endif
    } arb_state_e;

    // Request fields captured from the winning port at grant time.
    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [1:0]  size;
    } arb_req_t;

    // Port-index width; a single port still gets a 1-bit index tied to 0.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dm_sba_arbiter_if.sv
// Bus bundle between the debug-module requesters, the arbiter and the AXI
// adapter. The slave modport is the arbiter's view; master is the view of
// the surrounding environment (requesters plus adapter).
interface dm_sba_arbiter_if #(
    parameter int NrPorts    = 2,
    parameter int AxiIdWidth = 10
) ();
    import dm_sba_arbiter_pkg::*;

    // Requester side
    logic [NrPorts-1:0]         req_i;
    logic [NrPorts-1:0]         we_i;
    logic [NrPorts-1:0][63:0]   addr_i;
    logic [NrPorts-1:0][63:0]   wdata_i;
    logic [NrPorts-1:0][7:0]    be_i;
    logic [NrPorts-1:0][1:0]    size_i;
    logic [NrPorts-1:0]         gnt_o;
    logic [NrPorts-1:0]         rvalid_o;
    logic [63:0]                rdata_o;
    logic                       err_o;
    logic                       clr_err_i;

    // Adapter side
    logic                       req_o;
    ad_req_t                    type_o;
    logic                       we_o;
    logic [63:0]                addr_o;
    logic [63:0]                wdata_o;
    logic [7:0]                 be_o;
    logic [1:0]                 size_o;
    logic [AxiIdWidth-1:0]      id_o;
    logic                       gnt_i;
    logic                       valid_i;
    logic [63:0]                rdata_i;
    logic [AxiIdWidth-1:0]      id_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i, size_i, clr_err_i,
               gnt_i, valid_i, rdata_i, id_i,
        output gnt_o, rvalid_o, rdata_o, err_o,
               req_o, type_o, we_o, addr_o, wdata_o, be_o, size_o, id_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i, size_i, clr_err_i,
               gnt_i, valid_i, rdata_i, id_i,
        input  gnt_o, rvalid_o, rdata_o, err_o,
               req_o, type_o, we_o, addr_o, wdata_o, be_o, size_o, id_o
    );

endinterface

// File: rtl/dm_sba_arbiter_rr_pick.sv
// Combinational round-robin selector: the first asserted request at or after
// the pointer (wrapping) wins. Reports the winner one-hot, as an index, and
// whether any request was present.
module dm_sba_arbiter_rr_pick #(
    parameter int NrPorts = 2,
    parameter int IdxW    = 1
) (
    input  logic [NrPorts-1:0] i_req,
    input  logic [IdxW-1:0]    i_ptr,
    output logic [NrPorts-1:0] o_onehot,
    output logic [IdxW-1:0]    o_idx,
    output logic               o_any
);

    // Scan ports in priority order starting from the pointer.
    always_comb begin
        int j;
        // NOTE: every output gets a default before the scan so no path leaves it unassigned (no latch).
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        j        = 0;
        for (int off = 0; off < NrPorts; off++) begin
            j = int'(i_ptr) + off;
            if (j >= NrPorts) j = j - NrPorts;
            for (int p = 0; p < NrPorts; p++) begin
                if (p == j && i_req[p] && !o_any) begin
                    o_any       = 1'b1;
                    o_idx       = IdxW'(p);
                    o_onehot[p] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dm_sba_arbiter.sv
// Round-robin arbiter merging NrPorts single-word debug-module requesters onto
// the AXI adapter request port, one transaction outstanding at a time, and
// routing each response back to the port that issued it.
// Optional: DM_SBA_ARB_RSP_REG_EN registers the response (adds the RSP state,
// one cycle of valid_i -> rvalid_o latency, flopped rdata_o).
module dm_sba_arbiter
    import dm_sba_arbiter_pkg::*;
#(
    parameter int NrPorts    = 2,
    parameter int AxiIdWidth = 10
) (
    input logic             clk_i,
    input logic             rst_ni,
    dm_sba_arbiter_if.slave bus
);

    localparam int IDX_W = idx_w(NrPorts);

    arb_state_e         r_state, w_state_d;
    logic [IDX_W-1:0]   r_ptr, w_ptr_d, w_ptr_next;
    logic [IDX_W-1:0]   r_owner, w_pick_idx;
    logic [NrPorts-1:0] w_pick_oh, w_owner_oh, w_gnt, w_rvalid;
    logic               w_pick_any, w_capture, w_req;
    logic               r_err, w_err_d, w_err_set, w_id_mismatch;
    arb_req_t           r_cap, w_cap_d;

    dm_sba_arbiter_rr_pick #(
        .NrPorts (NrPorts),
        .IdxW    (IDX_W)
    ) u_rr_pick (
        .i_req    (bus.req_i),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // Pointer moves just past the winner; with one port it stays at 0.
    assign w_ptr_next = (int'(w_pick_idx) == NrPorts - 1) ? '0 : w_pick_idx + IDX_W'(1);

    assign w_cap_d = '{
        we:    bus.we_i[w_pick_idx],
        addr:  bus.addr_i[w_pick_idx],
        wdata: bus.wdata_i[w_pick_idx],
        be:    bus.be_i[w_pick_idx],
        size:  bus.size_i[w_pick_idx]
    };

    assign w_id_mismatch = (bus.id_i != AxiIdWidth'(r_owner));

    // Decode the transaction owner to a one-hot completion vector.
    always_comb begin
        w_owner_oh          = '0;
        w_owner_oh[r_owner] = 1'b1;
    end

`ifdef DM_SBA_ARB_RSP_REG_EN
    logic [63:0]        r_rsp_data;
    logic [IDX_W-1:0]   r_rsp_owner;
    logic [NrPorts-1:0] w_rsp_owner_oh;

    // Decode the registered response owner for the RSP cycle.
    always_comb begin
        w_rsp_owner_oh              = '0;
        w_rsp_owner_oh[r_rsp_owner] = 1'b1;
    end

    // Register the adapter response and its owner when it arrives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_data  <= '0;
            r_rsp_owner <= '0;
        end else if (r_state == WAIT_RSP && bus.valid_i) begin
            r_rsp_data  <= bus.rdata_i;
            r_rsp_owner <= r_owner;
        end
    end
`else
    logic [63:0] w_rdata;
`endif

    // State, pointer, sticky error and the captured request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the capture registers are reset too so the adapter never sees X fields after reset.
            r_state <= IDLE;
            r_ptr   <= '0;
            r_err   <= 1'b0;
            r_owner <= '0;
            r_cap   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            r_state <= w_state_d;
            r_ptr   <= w_ptr_d;
            r_err   <= w_err_d;
            if (w_capture) begin
                r_owner <= w_pick_idx;
                r_cap   <= w_cap_d;
            end
        end
    end

    // Next-state logic and per-state outputs.
    always_comb begin
        w_state_d = r_state;
        w_ptr_d   = r_ptr;
        w_capture = 1'b0;
        w_gnt     = '0;
        w_req     = 1'b0;
        w_rvalid  = '0;
        w_err_set = 1'b0;
`ifndef DM_SBA_ARB_RSP_REG_EN
        w_rdata   = '0;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_gnt     = w_pick_oh;
                    w_capture = 1'b1;
                    w_ptr_d   = w_ptr_next;
                    w_state_d = ISSUE;
                end
            end
            ISSUE: begin
                w_req = 1'b1;
                if (bus.gnt_i) w_state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (bus.valid_i) begin
                    // A wrong response ID still completes toward the owner.
                    w_err_set = w_id_mismatch;
`ifdef DM_SBA_ARB_RSP_REG_EN
                    w_state_d = RSP;
`else
                    w_rvalid  = w_owner_oh;
                    w_rdata   = bus.rdata_i;
                    w_state_d = IDLE;
`endif
                end
            end
`ifdef DM_SBA_ARB_RSP_REG_EN
            RSP: begin
                w_rvalid  = w_rsp_owner_oh;
                w_state_d = IDLE;
            end
`endif
            default: w_state_d = IDLE;
        endcase

        // A response with nothing outstanding is flagged and dropped.
        if (bus.valid_i && r_state != WAIT_RSP) w_err_set = 1'b1;

        // Setting wins over a simultaneous clear.
        w_err_d = w_err_set | (r_err & ~bus.clr_err_i);
    end

    assign bus.gnt_o    = w_gnt;
    assign bus.rvalid_o = w_rvalid;
    assign bus.err_o    = r_err;
    assign bus.req_o    = w_req;
    assign bus.type_o   = SINGLE_REQ;
    assign bus.we_o     = r_cap.we;
    assign bus.addr_o   = r_cap.addr;
    assign bus.wdata_o  = r_cap.wdata;
    assign bus.be_o     = r_cap.be;
    assign bus.size_o   = r_cap.size;
    assign bus.id_o     = AxiIdWidth'(r_owner);
`ifdef DM_SBA_ARB_RSP_REG_EN
    assign bus.rdata_o  = r_rsp_data;
`else
    assign bus.rdata_o  = w_rdata;
`endif

endmodule
